// File: rtl/wb_merge.sv
// Write-back merge: pipeline write-back plus buffered result channels
// share one register-file write port, round-robin in free cycles.
module wb_merge #(
  parameter int DATA_W     = 32,
  parameter int RF_AW      = 5,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_wen,
  input  logic [RF_AW-1:0]           pipe_waddr,
  input  logic [DATA_W-1:0]          pipe_wdata,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          ch_ready,
  input  logic [NUM_CH*RF_AW-1:0]    ch_waddr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic                       wb_reg_wen,
  output logic [RF_AW-1:0]           wb_reg_waddr,
  output logic [DATA_W-1:0]          wb_reg_wdata,
  output logic [(1<<RF_AW)-1:0]      pend_mask,
  output logic                       wb_stall_req
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [RF_AW-1:0]      m_addr   [NUM_CH][FIFO_DEPTH];
  logic [DATA_W-1:0]     m_data   [NUM_CH][FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_vld [NUM_CH];
  logic [PW-1:0]         wr_ptr   [NUM_CH];
  logic [PW-1:0]         rd_ptr   [NUM_CH];
  logic [SW-1:0]         cnt      [NUM_CH];

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  logic [CW-1:0]     rr_ptr;
  logic [CW-1:0]     rr_nxt;
  logic [CW-1:0]     gnt_idx;
  logic              pipe_gnt;
  logic              fifo_gnt;
  logic [RF_AW-1:0]  head_addr;
  logic [DATA_W-1:0] head_data;

  // FIFO status from registered pointers; zero-address pushes are dropped
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]) &&
                 (wr_ptr[i][AW] != rd_ptr[i][AW]);
      push[i]  = ch_valid[i] && !full[i] &&
                 (ch_waddr[i*RF_AW +: RF_AW] != '0);
    end
  end

  assign ch_ready = ~full;

  // Pipeline first, then round-robin search from rr_ptr
  always_comb begin
    int idx;
    idx      = 0;
    pipe_gnt = pipe_wen && (pipe_waddr != '0);
    fifo_gnt = 1'b0;
    gnt_idx  = '0;
    if (!pipe_gnt) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_CH;
        if (!fifo_gnt && !empty[idx]) begin
          fifo_gnt = 1'b1;
          gnt_idx  = CW'(idx);
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      pop[i] = fifo_gnt && (gnt_idx == CW'(i));
    end
    rr_nxt    = (int'(gnt_idx) + 1 == NUM_CH) ? '0 : gnt_idx + 1'b1;
    head_addr = m_addr[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];
    head_data = m_data[gnt_idx][rd_ptr[gnt_idx][AW-1:0]];
  end

  // FIFO storage, written at the tail on accepted pushes
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        m_addr[i][wr_ptr[i][AW-1:0]] <= ch_waddr[i*RF_AW +: RF_AW];
        m_data[i][wr_ptr[i][AW-1:0]] <= ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO pointers, per-slot valid bits and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        slot_vld[i] <= '0;
      end
    end else begin
      if (fifo_gnt) rr_ptr <= rr_nxt;
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
          slot_vld[i][rd_ptr[i][AW-1:0]] <= 1'b0;
        end
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
          slot_vld[i][wr_ptr[i][AW-1:0]] <= 1'b1;
        end
      end
    end
  end

  // Starvation counters: count ungranted cycles while non-empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst || empty[i] || pop[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] != SW'(STARVE_LIM)) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Stall request from saturated counters only
  always_comb begin
    wb_stall_req = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt[i] == SW'(STARVE_LIM)) wb_stall_req = 1'b1;
    end
  end

  // Pending-write mask over every queued entry
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (slot_vld[i][j]) pend_mask[m_addr[i][j]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  // Register-file write port register
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_reg_wen   <= 1'b0;
      wb_reg_waddr <= '0;
      wb_reg_wdata <= '0;
    end else begin
      wb_reg_wen <= pipe_gnt || fifo_gnt;
      if (pipe_gnt) begin
        wb_reg_waddr <= pipe_waddr;
        wb_reg_wdata <= pipe_wdata;
      end else if (fifo_gnt) begin
        wb_reg_waddr <= head_addr;
        wb_reg_wdata <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: reset, pipeline path, channel
// round-robin, backpressure, starvation stall, zero-address drop.
module tb_wb_merge;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NC = 2;

  logic          clk;
  logic          rst;
  logic          pipe_wen;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic [NC-1:0] ch_valid;
  logic [NC-1:0] ch_ready;
  logic [NC*AW-1:0] ch_waddr;
  logic [NC*DW-1:0] ch_wdata;
  logic          wb_reg_wen;
  logic [AW-1:0] wb_reg_waddr;
  logic [DW-1:0] wb_reg_wdata;
  logic [31:0]   pend_mask;
  logic          wb_stall_req;

  int n_chk;
  int n_err;

  wb_merge #(
    .DATA_W(DW), .RF_AW(AW), .NUM_CH(NC),
    .FIFO_DEPTH(4), .STARVE_LIM(8)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_waddr(ch_waddr), .ch_wdata(ch_wdata),
    .wb_reg_wen(wb_reg_wen), .wb_reg_waddr(wb_reg_waddr),
    .wb_reg_wdata(wb_reg_wdata),
    .pend_mask(pend_mask), .wb_stall_req(wb_stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    ch_valid[c]          = v;
    ch_waddr[c*AW +: AW] = a;
    ch_wdata[c*DW +: DW] = d;
  endtask

  task automatic set_pipe(input logic v, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    pipe_wen   = v;
    pipe_waddr = a;
    pipe_wdata = d;
  endtask

  // Protocol and invariant monitor, sampled mid-cycle
  always @(negedge clk) begin
    check("proto_stall", {63'd0, pipe_wen && wb_stall_req}, 64'd0);
    check("wen_r0",
          {63'd0, wb_reg_wen && (wb_reg_waddr == '0)}, 64'd0);
  end

  logic [AW-1:0] ea [9];
  logic [DW-1:0] ed [9];
  int n;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    set_pipe(1'b0, '0, '0);
    ch_valid = '0;
    ch_waddr = '0;
    ch_wdata = '0;
    ea = '{5'd16, 5'd8, 5'd17, 5'd9, 5'd18, 5'd10, 5'd19, 5'd11, 5'd12};
    ed = '{32'hB0, 32'hA0, 32'hB1, 32'hA1, 32'hB2,
           32'hA2, 32'hB3, 32'hA3, 32'hA4};

    // reset state
    tick();
    tick();
    check("rst_wen", 64'(wb_reg_wen), 64'd0);
    check("rst_addr", 64'(wb_reg_waddr), 64'd0);
    check("rst_data", 64'(wb_reg_wdata), 64'd0);
    check("rst_pend", 64'(pend_mask), 64'd0);
    check("rst_stall", 64'(wb_stall_req), 64'd0);
    check("rst_ready", 64'(ch_ready), 64'h3);

    // pipeline write, 1-cycle latency
    rst = 1'b1;
    set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    set_pipe(1'b0, '0, '0);
    check("pipe_wen", 64'(wb_reg_wen), 64'd1);
    check("pipe_addr", 64'(wb_reg_waddr), 64'd5);
    check("pipe_data", 64'(wb_reg_wdata), 64'hDEADBEEF);
    check("pipe_pend", 64'(pend_mask), 64'd0);

    // single channel entry, 2-cycle latency
    set_ch(0, 1'b1, 5'd3, 32'h11);
    tick();
    set_ch(0, 1'b0, '0, '0);
    check("ch0_pend", 64'(pend_mask), 64'h8);
    check("ch0_nobyp", 64'(wb_reg_wen), 64'd0);
    tick();
    check("ch0_wen", 64'(wb_reg_wen), 64'd1);
    check("ch0_addr", 64'(wb_reg_waddr), 64'd3);
    check("ch0_data", 64'(wb_reg_wdata), 64'h11);
    check("ch0_pclr", 64'(pend_mask), 64'd0);
    tick();
    check("ch0_idle", 64'(wb_reg_wen), 64'd0);

    // fill both FIFOs while the pipeline owns the port
    for (int c = 0; c < 4; c++) begin
      set_ch(0, 1'b1, AW'(8 + c), DW'(32'hA0 + c));
      set_ch(1, 1'b1, AW'(16 + c), DW'(32'hB0 + c));
      set_pipe(1'b1, 5'd1, DW'(c));
      tick();
    end
    set_ch(1, 1'b0, '0, '0);
    set_ch(0, 1'b1, 5'd12, 32'hA4);
    set_pipe(1'b0, '0, '0);
    check("full_ready", 64'(ch_ready), 64'd0);
    check("full_pend", 64'(pend_mask), 64'h000F0F00);
    check("full_pipe", 64'(wb_reg_waddr), 64'd1);

    // drain round-robin; fifth ch0 push must be held then taken
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 2) set_ch(0, 1'b0, '0, '0);
      check($sformatf("rr_wen%0d", k), 64'(wb_reg_wen), 64'd1);
      check($sformatf("rr_addr%0d", k), 64'(wb_reg_waddr), 64'(ea[k]));
      check($sformatf("rr_data%0d", k), 64'(wb_reg_wdata), 64'(ed[k]));
      if (k == 0) check("rdy_pop1", 64'(ch_ready), 64'h2);
      if (k == 1) check("rdy_pop2", 64'(ch_ready), 64'h3);
    end
    check("rr_pend", 64'(pend_mask), 64'd0);
    tick();
    check("rr_idle", 64'(wb_reg_wen), 64'd0);

    // starvation of channel 1 under continuous pipeline writes
    set_ch(1, 1'b1, 5'd21, 32'hC1);
    set_pipe(1'b1, 5'd2, 32'h22);
    tick();
    set_ch(1, 1'b0, '0, '0);
    check("stv_pend", 64'(pend_mask), 64'h00200000);
    check("stv_stall0", 64'(wb_stall_req), 64'd0);
    n = 0;
    while (!wb_stall_req && n < 20) begin
      tick();
      n++;
    end
    set_pipe(1'b0, '0, '0);
    check("stv_cycles", 64'(n), 64'd8);
    tick();
    check("stv_wen", 64'(wb_reg_wen), 64'd1);
    check("stv_addr", 64'(wb_reg_waddr), 64'd21);
    check("stv_data", 64'(wb_reg_wdata), 64'hC1);
    check("stv_clr", 64'(wb_stall_req), 64'd0);

    // zero-address requests are dropped; FIFO takes the free cycle
    set_ch(1, 1'b1, 5'd25, 32'hD1);
    tick();
    set_ch(1, 1'b0, '0, '0);
    set_ch(0, 1'b1, 5'd0, 32'h55);
    set_pipe(1'b1, 5'd0, 32'h66);
    tick();
    set_ch(0, 1'b0, '0, '0);
    set_pipe(1'b0, '0, '0);
    check("z_wen", 64'(wb_reg_wen), 64'd1);
    check("z_addr", 64'(wb_reg_waddr), 64'd25);
    check("z_data", 64'(wb_reg_wdata), 64'hD1);
    check("z_pend", 64'(pend_mask), 64'd0);
    tick();
    check("z_drop", 64'(wb_reg_wen), 64'd0);

    // reset with three queued entries
    set_pipe(1'b1, 5'd4, 32'h44);
    set_ch(0, 1'b1, 5'd6, 32'hE0);
    set_ch(1, 1'b1, 5'd7, 32'hE1);
    tick();
    set_ch(0, 1'b1, 5'd13, 32'hE2);
    set_ch(1, 1'b0, '0, '0);
    tick();
    set_ch(0, 1'b0, '0, '0);
    check("mr_pend", 64'(pend_mask), 64'h000020C0);
    set_pipe(1'b0, '0, '0);
    rst = 1'b0;
    tick();
    check("mr_wen", 64'(wb_reg_wen), 64'd0);
    check("mr_addr", 64'(wb_reg_waddr), 64'd0);
    check("mr_data", 64'(wb_reg_wdata), 64'd0);
    check("mr_pclr", 64'(pend_mask), 64'd0);
    check("mr_ready", 64'(ch_ready), 64'h3);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mr_stale%0d", k), 64'(wb_reg_wen), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
